// File: rtl/mmio_monitor_pkg.sv
// Shared types and default addresses for the MMIO end-of-program monitor.
// The software linker script places the result word at DEFAULT_RESULT_ADDR.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package mmio_monitor_pkg;

    localparam int STATUS_W = 3;

    typedef enum logic [STATUS_W-1:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_WRONG   = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_HANG    = 3'd4,
        ST_NOINSTR = 3'd5
    } mon_status_t;

    localparam logic [31:0] DEFAULT_RESULT_ADDR    = 32'hC;
    localparam logic [31:0] DEFAULT_EXPECTED_VALUE = 32'h0F;

endpackage

// File: rtl/mmio_result_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mmio_result_monitor.sv
// Snoops stores and the fetch address, classifies how the program run ended
// and latches the verdict in registered status outputs.
module mmio_result_monitor
    import mmio_monitor_pkg::*;
#(
    parameter int                      BIT_COUNT      = `BIT_COUNT,
    parameter logic [BIT_COUNT-1:0]    RESULT_ADDR    = BIT_COUNT'(DEFAULT_RESULT_ADDR),
    parameter logic [BIT_COUNT-1:0]    EXPECTED_VALUE = BIT_COUNT'(DEFAULT_EXPECTED_VALUE),
    parameter int                      TIMEOUT_CYCLES = 10000,
    parameter int                      HANG_CYCLES    = 64,
    parameter int                      CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemEn,
    input  logic                 MemWrite,
    input  logic [BIT_COUNT-1:0] MemAdr,
    input  logic [BIT_COUNT-1:0] MemWriteData,
    input  logic [BIT_COUNT-1:0] InstrAdr,
    input  logic                 InstrValid,
    output logic                 Done,
    output logic                 Pass,
    output logic                 Fail,
    output logic [STATUS_W-1:0]  Status,
    output logic [BIT_COUNT-1:0] ResultValue,
    output logic [CNT_W-1:0]     CycleCount
);

    localparam int HANG_W = $clog2(HANG_CYCLES + 1);
    // Timeout compare is done at >=32 bits so a narrow counter can never alias the budget.
    localparam int TW     = (CNT_W > 32) ? CNT_W : 32;

    mon_status_t          state;
    mon_status_t          state_next;
    logic [BIT_COUNT-1:0] prev_pc;
    logic [HANG_W-1:0]    hang_count;
    logic                 running;
    logic                 pc_same;
    logic                 result_event;
    logic                 timeout_hit;
    logic                 hang_hit;
    logic                 capture;
    logic [TW-1:0]        cycle_wide;

    assign running      = (state == ST_RUN);
    assign pc_same      = (InstrAdr == prev_pc);
    assign result_event = MemEn && MemWrite && (MemAdr == RESULT_ADDR);
    assign cycle_wide   = TW'(CycleCount);
    assign timeout_hit  = (cycle_wide == TW'(TIMEOUT_CYCLES - 1));
    assign hang_hit     = (hang_count == HANG_W'(HANG_CYCLES - 1)) && pc_same;

    sat_counter #(.WIDTH(CNT_W)) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .en    (running),
        .count (CycleCount)
    );

    sat_counter #(.WIDTH(HANG_W)) u_hang_counter (
        .clk   (clk),
        .reset (reset),
        .clear (running && !pc_same),
        .en    (running),
        .count (hang_count)
    );

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        if (state == ST_RUN) begin
            if (result_event) begin
                capture    = 1'b1;
                state_next = (MemWriteData == EXPECTED_VALUE) ? ST_PASS : ST_WRONG;
            end else if (!InstrValid) begin
                state_next = ST_NOINSTR;
            end else if (timeout_hit) begin
                state_next = ST_TIMEOUT;
            end else if (hang_hit) begin
                state_next = ST_HANG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            prev_pc     <= '0;
            ResultValue <= '0;
        end else begin
            state <= state_next;
            if (running) begin
                prev_pc <= InstrAdr;
            end
            if (capture) begin
                ResultValue <= MemWriteData;
            end
        end
    end

    // Flags decode only the state register, so they never glitch with the bus.
    assign Done   = (state != ST_RUN);
    assign Pass   = (state == ST_PASS);
    assign Fail   = Done && !Pass;
    assign Status = state;

endmodule

// File: doc/mmio_result_monitor.md
# mmio_result_monitor

Synthesizable end-of-program monitor that sits downstream of the core's data-memory and fetch ports. It snoops stores and the fetch address, detects the program's result store to a fixed MMIO word, and classifies the run as pass, fail, timeout, hang or out-of-instructions. Status is latched in registered outputs for on-board LEDs and for lockstep benches.

## Interface
- `BIT_COUNT`, default `` `BIT_COUNT `` (32): data and address width.
- `RESULT_ADDR`, default 32'hC: byte address of the result word.
- `EXPECTED_VALUE`, default 32'h0F: value that constitutes a pass.
- `TIMEOUT_CYCLES`, default 10000: run-cycle budget, must be ≥ 2.
- `HANG_CYCLES`, default 64: consecutive cycles with unchanged `InstrAdr` that count as a hang, must be ≥ 2.
- `CNT_W`, default 32: width of the cycle counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemEn`  in  1  data-memory access this cycle.
- `MemWrite`  in  1  access is a store.
- `MemAdr`  in  BIT_COUNT  data byte address.
- `MemWriteData`  in  BIT_COUNT  store data.
- `InstrAdr`  in  BIT_COUNT  current fetch address.
- `InstrValid`  in  1  fetched word is defined; low means fetch beyond loaded image.
- `Done`  out  1  run has terminated (sticky).
- `Pass`  out  1  result store matched `EXPECTED_VALUE`.
- `Fail`  out  1  any terminal state other than pass.
- `Status`  out  3  terminal cause, `mon_status_t` encoding.
- `ResultValue`  out  BIT_COUNT  data of the captured result store.
- `CycleCount`  out  CNT_W  run cycles elapsed.

## Operation
- States: RUN, PASS, WRONG, TIMEOUT, HANG, NOINSTR. Encodings 0-5 in that order, driven on `Status`.
- Reset (any cycle, including mid-run or in a terminal state): state RUN. All outputs 0. Hang counter 0. Previous-PC register 0.
- Result event: `MemEn && MemWrite && MemAdr == RESULT_ADDR`. The address compare is full-width and exact. Sub-word or misaligned addresses do not match.
- In RUN, evaluated each edge in priority order:
  - Result event: capture `MemWriteData` into `ResultValue`. Go to PASS if the data equals `EXPECTED_VALUE`, otherwise WRONG.
  - `!InstrValid`: go to NOINSTR.
  - `CycleCount == TIMEOUT_CYCLES-1`: go to TIMEOUT.
  - Hang counter `== HANG_CYCLES-1` and `InstrAdr` unchanged: go to HANG.
- Terminal states are absorbing until reset. Later stores, including further result stores, are ignored. `ResultValue` does not change again.
- `Done = (state != RUN)`. `Pass = (state == PASS)`. `Fail = Done && !Pass`. All three are decoded from the state register, with no combinational path from the inputs.
- `CycleCount`:
  - Increments by 1 on every RUN edge, including the terminating edge.
  - Frozen in terminal states.
  - Saturates at 2^CNT_W-1 without wrapping.
- Hang counter:
  - Clears when `InstrAdr` differs from the registered previous `InstrAdr`; otherwise increments, saturating.
  - Previous-PC register updates every RUN edge.
  - Pipeline stalls shorter than `HANG_CYCLES` never trigger HANG.

## Timing
- Latency: event sampled at edge N. `Done`, `Pass`, `Fail`, `Status` and `ResultValue` are valid after edge N (one cycle).
- The first run edge is the first rising edge with `reset` low. That edge yields `CycleCount` 1.
- A timeout with no other event asserts `Done` after exactly `TIMEOUT_CYCLES` run edges, with `CycleCount == TIMEOUT_CYCLES`.
- Simultaneous events resolve by the priority above. For example, a result store together with `InstrValid` low gives PASS or WRONG.
- Reset asserted during the same edge as an event: reset wins.

## Structure
- Shared package `mmio_monitor_pkg` holds:
  - `mon_status_t` enum (3-bit, encodings above);
  - the status width constant;
  - default `RESULT_ADDR` and `EXPECTED_VALUE` localparams, so that the bench and software linker script agree.
- One sub-module, `sat_counter` (parameterised width, `clear`, `en`, synchronous reset, saturating). It is instantiated for `CycleCount` and for the hang counter.
- Top: state register, previous-PC register, result capture register, priority next-state logic.

## Test plan
- Program stores 32'h0F to 0xC at run cycle 40 → `Pass`=1, `Status`=1, `ResultValue`=32'h0F, `CycleCount`=40 one cycle later, then held for 100 further cycles.
- Store 32'h0E to 0xC, then 32'h0F to 0xC → WRONG (`Status`=2), `Fail`=1, `ResultValue`=32'h0E unchanged by the second store.
- Stores to 0x8, to 0xD, and a load from 0xC → no transition. Then `TIMEOUT_CYCLES`=50 with no further activity → `Status`=3 and `CycleCount`=50 after exactly 50 run edges.
- `InstrAdr` held at 0x20 for 63 cycles, changed, then held 64 cycles with `HANG_CYCLES`=64 → only the second hold yields `Status`=4.
- Result store 32'h0F coincident with `InstrValid`=0 → PASS. A separate run with `InstrValid`=0 alone → NOINSTR (`Status`=5).
- Assert `reset` for one cycle while in PASS, and again mid-run at cycle 20 → all outputs 0, `Status`=0, `CycleCount` restarts at 1 on the next edge.
